pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter generator for the fetch stage. It produces the 12-bit address that drives the instruction memory's `PCAdd_pc` input each cycle. It advances sequentially, applies branch, call and return redirects from decode, and holds the address on stall or halt. A small return-address stack (RAS) supports call/return without register-file traffic.

## Interface
Parameters:
- `PC_W`, default 12: PC width, matching the 4096-word instruction memory.
- `START_PC`, default 12'h000: PC value loaded by reset.
- `RAS_DEPTH`, default 4: number of return-address stack entries; must be a power of two.

Ports:
- `i_clk`  in  1  single clock, rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_stop`  in  1  stall; hold PC and RAS.
- `i_halt`  in  1  enter HALT at the next edge.
- `i_branch`  in  1  taken branch or jump.
- `i_target`  in  PC_W  branch or call target.
- `i_call`  in  1  call; push `i_link`, jump to `i_target`.
- `i_link`  in  PC_W  return address supplied by decode.
- `i_ret`  in  1  return; pop the RAS and jump to the popped address.
- `o_pc`  out  PC_W  fetch address, connects to `PCAdd_pc`.
- `o_valid`  out  1  `o_pc` is a real fetch.
- `o_halted`  out  1  FSM is in HALT.
- `o_ras_err`  out  1  sticky; set on RAS underflow, RAS overflow, or illegal `i_call & i_ret`.

## Operation
- FSM states: RUN, HALT.
  - RUN→HALT when `i_halt=1` and `i_stop=0`.
  - HALT is left only by reset.
- Next-PC priority in RUN with `i_stop=0`, highest first:
  1. `i_halt`: hold PC, go to HALT.
  2. `i_ret`: PC ← top of RAS, pop.
  3. `i_call`: PC ← `i_target`, push `i_link`.
  4. `i_branch`: PC ← `i_target`.
  5. Otherwise: PC ← PC+1, modulo 2^PC_W (4095→0).
- Illegal `i_call & i_ret`: the return executes, the call is dropped, and `o_ras_err` sets.
- Stall (`i_stop=1`):
  - PC, RAS and state are all held.
  - Every redirect or halt input presented that cycle is ignored. Decode must hold these inputs until the stall clears.
- RAS is circular, using a pointer plus a count (0..RAS_DEPTH).
  - Push when full: the oldest entry is overwritten, count stays RAS_DEPTH, `o_ras_err` sets.
  - Pop when empty: PC ← PC+1, count stays 0, `o_ras_err` sets.
- Reset, from any state including mid-stall or HALT:
  - `o_pc`=START_PC, `o_valid`=0, `o_halted`=0, `o_ras_err`=0.
  - RAS count=0, pointer=0, state=RUN.
- `o_valid`:
  - Registered. It is 0 during reset and for the first cycle after reset.
  - It is 1 thereafter in RUN, 0 in HALT, and unchanged during stall.

## Timing
- All state updates on the rising edge of `i_clk`. `o_pc` comes directly from a flop with no combinational path from inputs.
- Redirect latency: a redirect sampled at edge n appears on `o_pc` after edge n. The instruction memory's registered output shows the target instruction after edge n+1.
- Sequential path: one address per cycle. On the first cycle out of reset, START_PC is presented with `o_valid`=0 so memory can prime. At the next edge, PC stays START_PC and `o_valid` rises.
- Wrap: PC=12'hFFF with no redirect gives `o_pc`=12'h000 after the edge, with no error.
- Push and pop never occur in the same cycle, because the illegal combination resolves to a pop only.
- `o_ras_err` clears only on reset.

## Structure
- Shared package `cpu_pkg`:
  - `PC_W`
  - `START_PC`
  - `typedef` for PC (`logic [PC_W-1:0]`)
  - FSM state enum `fetch_state_t` {RUN, HALT}
- Sub-module `ras_stack`, instantiated once:
  - Inputs: `push`, `pop`, `din`.
  - Outputs: `top`, `empty`, `full`.
  - Handles the circular pointer and count.
- Top level holds the FSM, next-PC mux and error flag.

## Test plan
- Reset then free-run:
  - Release `i_reset`; `o_pc` reads 0, 0, 1, 2, 3.
  - `o_valid` is 0 for the first cycle, then 1.
- Branch during stall:
  - At PC=5, assert `i_branch`, `i_target`=12'h100, and `i_stop`=1 for 2 cycles.
  - `o_pc` holds at 5 throughout the stall.
  - With `i_stop` low and `i_branch`/`i_target` still held, `o_pc`=12'h100 after the next edge.
- Call/return nesting:
  - First call: `i_link`=12'h011, `i_target`=12'h200.
  - Second call: `i_link`=12'h201, `i_target`=12'h300.
  - Two returns follow: `o_pc` goes 12'h300, 12'h201, 12'h011, and `o_ras_err` stays 0.
- RAS overflow and underflow:
  - Five calls with links 1..5; `o_ras_err` sets on the 5th.
  - Five returns then yield 5, 4, 3, 2, then PC+1 on the underflowing 5th return.
- Wrap and halt:
  - Branch to 12'hFFF; next `o_pc`=12'h000.
  - Assert `i_halt`: `o_halted`=1, `o_valid`=0 and `o_pc` frozen while `i_branch` toggles.
  - Reset returns `o_pc` to 0 and clears all flags.
- Illegal simultaneous call and return:
  - With RAS top=12'h040, assert `i_call` and `i_ret` together.
  - `o_pc`=12'h040, RAS count decrements by one, `o_ras_err`=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: PC geometry, reset vector and FSM encoding.
package cpu_pkg;

    localparam int unsigned  PC_W     = 12;
    localparam logic [11:0]  START_PC = 12'h000;

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage : cpu_pkg

// File: rtl/ras_stack.sv
// Circular return-address stack. A push when full overwrites the oldest entry.
// A pop when empty is ignored here and reported upstream via empty.
module ras_stack #(
    parameter int unsigned W     = 12,
    parameter int unsigned DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] ptr_q;   // next slot to write; top of stack is ptr_q-1
    logic [CNT_W-1:0] cnt_q;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign top   = mem[ptr_q - PTR_W'(1)];

    // Pointer and occupancy; the pointer wraps naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push) begin
            ptr_q <= ptr_q + PTR_W'(1);
            if (!full) cnt_q <= cnt_q + CNT_W'(1);
        end else if (pop && !empty) begin
            ptr_q <= ptr_q - PTR_W'(1);
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Entry storage; contents need no reset since occupancy gates their use.
    always_ff @(posedge i_clk) begin
        if (push) mem[ptr_q] <= din;
    end

endmodule : ras_stack

// File: rtl/pc_fetch_unit.sv
// Fetch-stage program counter with branch/call/return redirects, stall, halt
// and a return-address stack.
module pc_fetch_unit #(
    parameter int unsigned          PC_W      = cpu_pkg::PC_W,
    parameter logic [PC_W-1:0]      START_PC  = cpu_pkg::START_PC,
    parameter int unsigned          RAS_DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_stop,
    input  logic            i_halt,
    input  logic            i_branch,
    input  logic [PC_W-1:0] i_target,
    input  logic            i_call,
    input  logic [PC_W-1:0] i_link,
    input  logic            i_ret,
    output logic [PC_W-1:0] o_pc,
    output logic            o_valid,
    output logic            o_halted,
    output logic            o_ras_err
);

    import cpu_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic            push, pop;
    logic [PC_W-1:0] ras_top;
    logic            ras_empty, ras_full;

    ras_stack #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .push    (push),
        .pop     (pop),
        .din     (i_link),
        .top     (ras_top),
        .empty   (ras_empty),
        .full    (ras_full)
    );

    // State, PC, valid and sticky error registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= RUN;
            pc_q    <= START_PC;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Next state: HALT is entered from an unstalled RUN and left only by reset.
    always_comb begin
        state_d = state_q;
        if (state_q == RUN && !i_stop && i_halt) state_d = HALT;
    end

    // Next PC, RAS control and error update. The first unstalled cycle after
    // reset only raises valid so memory can prime on START_PC.
    always_comb begin
        pc_d    = pc_q;
        valid_d = valid_q;
        err_d   = err_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (state_q == RUN && !i_stop) begin
            if (i_halt) begin
                valid_d = 1'b0;
            end else if (!valid_q) begin
                valid_d = 1'b1;
            end else if (i_ret) begin
                if (ras_empty) begin
                    pc_d  = pc_q + PC_W'(1);
                    err_d = 1'b1;
                end else begin
                    pc_d = ras_top;
                    pop  = 1'b1;
                end
                if (i_call) err_d = 1'b1;
            end else if (i_call) begin
                pc_d = i_target;
                push = 1'b1;
                if (ras_full) err_d = 1'b1;
            end else if (i_branch) begin
                pc_d = i_target;
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
        end
    end

    // Outputs straight from registered state.
    always_comb begin
        o_pc      = pc_q;
        o_valid   = valid_q;
        o_halted  = (state_q == HALT);
        o_ras_err = err_q;
    end

endmodule : pc_fetch_unit

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with hand-computed expected values.
module tb_pc_fetch_unit;

    logic        i_clk = 1'b0;
    logic        i_reset, i_stop, i_halt, i_branch, i_call, i_ret;
    logic [11:0] i_target, i_link;
    logic [11:0] o_pc;
    logic        o_valid, o_halted, o_ras_err;

    int n_checks = 0;
    int n_fail   = 0;

    pc_fetch_unit #(
        .PC_W      (12),
        .START_PC  (12'h000),
        .RAS_DEPTH (4)
    ) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_stop    (i_stop),
        .i_halt    (i_halt),
        .i_branch  (i_branch),
        .i_target  (i_target),
        .i_call    (i_call),
        .i_link    (i_link),
        .i_ret     (i_ret),
        .o_pc      (o_pc),
        .o_valid   (o_valid),
        .o_halted  (o_halted),
        .o_ras_err (o_ras_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_reset = 1'b1; i_stop = 1'b0; i_halt = 1'b0; i_branch = 1'b0;
        i_call = 1'b0; i_ret = 1'b0; i_target = '0; i_link = '0;
        step(); step();
        check("rst_pc", 32'(o_pc), 32'h000);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_halted", 32'(o_halted), 32'd0);
        check("rst_err", 32'(o_ras_err), 32'd0);

        // Free run: 0 (prime), 0 valid, 1, 2, 3, 4, 5
        i_reset = 1'b0;
        step();
        check("prime_pc", 32'(o_pc), 32'h000);
        check("prime_valid", 32'(o_valid), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            step();
            check("seq_pc", 32'(o_pc), 32'(k));
        end
        check("seq_valid", 32'(o_valid), 32'd1);

        // Branch presented during a two-cycle stall
        i_branch = 1'b1; i_target = 12'h100; i_stop = 1'b1;
        step(); check("stall_pc0", 32'(o_pc), 32'h005);
        step(); check("stall_pc1", 32'(o_pc), 32'h005);
        check("stall_valid", 32'(o_valid), 32'd1);
        i_stop = 1'b0;
        step(); check("br_pc", 32'(o_pc), 32'h100);
        i_branch = 1'b0;
        step(); check("br_seq", 32'(o_pc), 32'h101);

        // Nested call / return
        i_call = 1'b1; i_link = 12'h011; i_target = 12'h200;
        step(); check("call1_pc", 32'(o_pc), 32'h200);
        i_link = 12'h201; i_target = 12'h300;
        step(); check("call2_pc", 32'(o_pc), 32'h300);
        i_call = 1'b0; i_ret = 1'b1;
        step(); check("ret1_pc", 32'(o_pc), 32'h201);
        step(); check("ret2_pc", 32'(o_pc), 32'h011);
        i_ret = 1'b0;
        check("nest_err", 32'(o_ras_err), 32'd0);
        step(); check("nest_seq", 32'(o_pc), 32'h012);

        // Overflow: five pushes into a four-entry stack
        i_call = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            i_link = 12'(k); i_target = 12'h400 + 12'(k);
            step();
            check("ovf_pc", 32'(o_pc), 32'h400 + 32'(k));
            check("ovf_err", 32'(o_ras_err), (k == 5) ? 32'd1 : 32'd0);
        end
        i_call = 1'b0; i_ret = 1'b1;
        for (int k = 5; k >= 2; k--) begin
            step();
            check("pop_pc", 32'(o_pc), 32'(k));
        end
        step(); check("udf_pc", 32'(o_pc), 32'h003);
        check("udf_err", 32'(o_ras_err), 32'd1);
        i_ret = 1'b0;

        // Wrap then halt
        i_branch = 1'b1; i_target = 12'hFFF;
        step(); check("wrap_ff", 32'(o_pc), 32'hFFF);
        i_branch = 1'b0;
        step(); check("wrap_0", 32'(o_pc), 32'h000);
        step(); check("wrap_1", 32'(o_pc), 32'h001);
        i_halt = 1'b1;
        step();
        check("halt_halted", 32'(o_halted), 32'd1);
        check("halt_valid", 32'(o_valid), 32'd0);
        check("halt_pc", 32'(o_pc), 32'h001);
        i_halt = 1'b0; i_target = 12'h123;
        for (int k = 0; k < 4; k++) begin
            i_branch = ~i_branch;
            step();
            check("halt_frozen", 32'(o_pc), 32'h001);
            check("halt_stay", 32'(o_halted), 32'd1);
        end
        i_branch = 1'b0;
        i_reset = 1'b1;
        step();
        check("rst2_pc", 32'(o_pc), 32'h000);
        check("rst2_halted", 32'(o_halted), 32'd0);
        check("rst2_valid", 32'(o_valid), 32'd0);
        check("rst2_err", 32'(o_ras_err), 32'd0);

        // Illegal call+return: return wins, call is dropped, error sets
        i_reset = 1'b0;
        step(); check("prime2_pc", 32'(o_pc), 32'h000);
        i_call = 1'b1; i_link = 12'h040; i_target = 12'h050;
        step(); check("ill_call", 32'(o_pc), 32'h050);
        check("ill_pre_err", 32'(o_ras_err), 32'd0);
        i_ret = 1'b1; i_link = 12'h777; i_target = 12'h999;
        step();
        check("ill_pc", 32'(o_pc), 32'h040);
        check("ill_err", 32'(o_ras_err), 32'd1);
        i_call = 1'b0;
        step();
        check("ill_empty", 32'(o_pc), 32'h041);
        i_ret = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pc_fetch_unit
